// File: rtl/ppi_access_arbiter.sv
// ppi_access_arbiter: two-requester arbiter sequencing single accesses to an 8255-style PPI
module ppi_access_arbiter #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] ppi_rdata,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       ppi_cs,
  output logic       ppi_rd,
  output logic       ppi_wr,
  output logic [1:0] ppi_addr,
  output logic [7:0] ppi_wdata
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_gnt;
  logic       r_we;
  logic       w_gnt;
  // on a tie, round-robin hands the grant to whoever did not win last time
  assign w_gnt = (req0 && req1) ? (FIXED_PRIORITY ? 1'b0 : ~r_last) : req1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_we      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      ppi_cs    <= 1'b0;
      ppi_rd    <= 1'b0;
      ppi_wr    <= 1'b0;
      ppi_addr  <= '0;
      ppi_wdata <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        IDLE:
          if (req0 || req1) begin
            r_state   <= SETUP;
            r_gnt     <= w_gnt;
            r_last    <= w_gnt;
            r_we      <= w_gnt ? we1 : we0;
            ppi_addr  <= w_gnt ? addr1 : addr0;
            ppi_wdata <= w_gnt ? wdata1 : wdata0;
            ppi_cs    <= 1'b1;
            busy      <= 1'b1;
          end
        SETUP: begin
          r_state <= STROBE;
          r_cnt   <= '0;
          ppi_wr  <= r_we;
          ppi_rd  <= ~r_we;
        end
        STROBE:
          if (r_cnt == LAST) begin
            r_state <= HOLD;
            ppi_wr  <= 1'b0;
            ppi_rd  <= 1'b0;
            if (!r_we) rdata <= ppi_rdata;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        HOLD: begin
          r_state <= DONE;
          ppi_cs  <= 1'b0;
          ack0    <= ~r_gnt;
          ack1    <= r_gnt;
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ppi_access_arbiter.sv
// tb_ppi_access_arbiter: scoreboard bench for the default arbiter plus directed checks of parameter variants
module tb_ppi_access_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0;
  int fails = 0;
  logic       rst_n, req0, req1, we0, we1, ack0, ack1, busy, cs, rd, wr;
  logic [1:0] addr0, addr1, paddr;
  logic [7:0] wdata0, wdata1, rdata, pwdata, prdata;
  logic [7:0] ppi_reg [4] = '{8'h00, 8'h5A, 8'hC3, 8'h00};
  assign prdata = ppi_reg[paddr];
  ppi_access_arbiter u_dut (
    .clock(clk), .reset_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .ppi_rdata(prdata),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .ppi_cs(cs), .ppi_rd(rd),
    .ppi_wr(wr), .ppi_addr(paddr), .ppi_wdata(pwdata));
  logic       x_rst_n, x_req0, x_req1, x_we0, x_we1;
  logic [1:0] x_addr0, x_addr1;
  logic [7:0] x_wdata0, x_wdata1;
  logic [7:0] x_prdata = 8'hA5;
  logic       s1_ack0, s1_ack1, s1_busy, s1_cs, s1_rd, s1_wr;
  logic       s15_ack0, s15_ack1, s15_busy, s15_cs, s15_rd, s15_wr;
  logic       fx_ack0, fx_ack1, fx_busy, fx_cs, fx_rd, fx_wr;
  logic [1:0] s1_paddr, s15_paddr, fx_paddr;
  logic [7:0] s1_rdata, s15_rdata, fx_rdata, s1_pwdata, s15_pwdata, fx_pwdata;
  ppi_access_arbiter #(.STROBE_CYCLES(1)) u_s1 (
    .clock(clk), .reset_n(x_rst_n), .req0(x_req0), .req1(x_req1), .we0(x_we0), .we1(x_we1),
    .addr0(x_addr0), .addr1(x_addr1), .wdata0(x_wdata0), .wdata1(x_wdata1), .ppi_rdata(x_prdata),
    .ack0(s1_ack0), .ack1(s1_ack1), .rdata(s1_rdata), .busy(s1_busy), .ppi_cs(s1_cs), .ppi_rd(s1_rd),
    .ppi_wr(s1_wr), .ppi_addr(s1_paddr), .ppi_wdata(s1_pwdata));
  ppi_access_arbiter #(.STROBE_CYCLES(15)) u_s15 (
    .clock(clk), .reset_n(x_rst_n), .req0(x_req0), .req1(x_req1), .we0(x_we0), .we1(x_we1),
    .addr0(x_addr0), .addr1(x_addr1), .wdata0(x_wdata0), .wdata1(x_wdata1), .ppi_rdata(x_prdata),
    .ack0(s15_ack0), .ack1(s15_ack1), .rdata(s15_rdata), .busy(s15_busy), .ppi_cs(s15_cs), .ppi_rd(s15_rd),
    .ppi_wr(s15_wr), .ppi_addr(s15_paddr), .ppi_wdata(s15_pwdata));
  ppi_access_arbiter #(.FIXED_PRIORITY(1'b1)) u_fx (
    .clock(clk), .reset_n(x_rst_n), .req0(x_req0), .req1(x_req1), .we0(x_we0), .we1(x_we1),
    .addr0(x_addr0), .addr1(x_addr1), .wdata0(x_wdata0), .wdata1(x_wdata1), .ppi_rdata(x_prdata),
    .ack0(fx_ack0), .ack1(fx_ack1), .rdata(fx_rdata), .busy(fx_busy), .ppi_cs(fx_cs), .ppi_rd(fx_rd),
    .ppi_wr(fx_wr), .ppi_addr(fx_paddr), .ppi_wdata(fx_pwdata));
  typedef struct {
    logic       id;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         issue;
    int         lat;
    bit         rel;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: protocol invariants, PPI register model and scoreboard pops on every ack
  int   wcnt = 0, glow = 0, last_ack = 0;
  bit   pstb = 0, pcs = 0, pwr = 0, seen = 0;
  logic [7:0] mdl_rd = 8'h00;
  always @(negedge clk)
    if (!rst_n) begin
      wcnt = 0; glow = 0; pstb = 0; pcs = 0; pwr = 0; seen = 0; mdl_rd = 8'h00;
    end else begin
      chk("proto", {29'd0, rd & wr, (rd | wr) & ~cs, ack0 & ack1}, 32'd0);
      if (pwr && !wr && cs) ppi_reg[paddr] = pwdata;
      if (pstb && !(rd | wr)) begin
        chk("strobe_width", wcnt, 2);
        chk("cs_in_hold", cs, 1);
        wcnt = 0;
      end
      if (rd | wr) wcnt++;
      if (!pcs && cs && seen) chk("cs_gap_ge2", glow >= 2, 1);
      if (cs) begin seen = 1; glow = 0; end else glow++;
      if (ack0 | ack1) begin
        if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("ack_id", ack1, e.id);
          chk("ack_addr", paddr, e.addr);
          if (e.we) chk("ack_wdata", pwdata, e.wdata);
          else mdl_rd = e.rdata;
          chk("rdata", rdata, mdl_rd);
          chk("busy_at_ack", busy, 1);
          chk("latency", cyc - (e.rel ? last_ack : e.issue), e.lat);
        end
        last_ack = cyc;
      end
      pstb = rd | wr; pwr = wr; pcs = cs;
    end
  task automatic txn(input bit id, input bit we, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] rx, input bit early);
    @(negedge clk);
    if (id) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    sb.push_back(exp_t'{id, we, a, d, rx, cyc, 5, 1'b0});
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (early && k == 1) begin if (id) req1 = 1'b0; else req0 = 1'b0; end
      if (id ? ack1 : ack0) break;
    end
    chk("ack_seen", id ? ack1 : ack0, 1);
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, l1, l15, lf, w1, w15, c0, c1, lf1;
    logic [7:0] rdf;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    x_rst_n = 0; x_req0 = 0; x_req1 = 0; x_we0 = 0; x_we1 = 0; x_addr0 = 0; x_addr1 = 0;
    x_wdata0 = 0; x_wdata1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack0, ack1, rdata, busy, cs, rd, wr, paddr, pwdata}, 0);
    @(negedge clk);
    #2 rst_n = 1; x_rst_n = 1;
    txn(0, 1, 2'd3, 8'h80, 8'h00, 0);
    chk("ctrl_reg", ppi_reg[3], 8'h80);
    txn(1, 0, 2'd1, 8'h00, 8'h5A, 0);
    // both held: last grant was 1, so order is 0,1,0,1 spaced STROBE+4 apart
    @(negedge clk);
    we0 = 1; addr0 = 2'd0; wdata0 = 8'h11; we1 = 0; addr1 = 2'd2; req0 = 1; req1 = 1;
    sb.push_back(exp_t'{1'b0, 1'b1, 2'd0, 8'h11, 8'h00, cyc, 5, 1'b0});
    sb.push_back(exp_t'{1'b1, 1'b0, 2'd2, 8'h00, 8'hC3, cyc, 6, 1'b1});
    sb.push_back(exp_t'{1'b0, 1'b1, 2'd0, 8'h11, 8'h00, cyc, 6, 1'b1});
    sb.push_back(exp_t'{1'b1, 1'b0, 2'd2, 8'h00, 8'hC3, cyc, 6, 1'b1});
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (ack0 | ack1) n++;
    end
    chk("rr_acks", n, 4);
    req0 = 0; req1 = 0;
    @(negedge clk);
    we0 = 1; addr0 = 2'd0; wdata0 = 8'h77; req0 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr) break;
    end
    chk("wr_before_abort", wr, 1);
    #2 rst_n = 0;
    #1 chk("reset_abort", {ack0, ack1, rdata, busy, cs, rd, wr, paddr, pwdata}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    sb.push_back(exp_t'{1'b0, 1'b1, 2'd0, 8'h77, 8'h00, cyc, 5, 1'b0});
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack0) break;
    end
    chk("ack_after_reset", ack0, 1);
    req0 = 0;
    chk("regA_after_reset", ppi_reg[0], 8'h77);
    txn(1, 1, 2'd2, 8'h3C, 8'h00, 1);
    chk("regC_after_drop", ppi_reg[2], 8'h3C);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    // strobe width and latency at STROBE_CYCLES 1 and 15
    @(negedge clk);
    x_we0 = 1; x_addr0 = 2'd3; x_wdata0 = 8'h80; x_req0 = 1;
    l1 = 0; l15 = 0; lf = 0; w1 = 0; w15 = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (l1 == 0) w1 += int'(s1_wr);
      if (l15 == 0) w15 += int'(s15_wr);
      if (s1_ack0 && l1 == 0) l1 = k;
      if (s15_ack0 && l15 == 0) l15 = k;
      if (fx_ack0 && lf == 0) lf = k;
    end
    x_req0 = 0;
    chk("s1_wr_width", w1, 1);
    chk("s15_wr_width", w15, 15);
    chk("s1_latency", l1, 4);
    chk("s15_latency", l15, 18);
    chk("fx_single_latency", lf, 5);
    @(negedge clk);
    #2 x_rst_n = 0;
    @(negedge clk);
    #2 x_rst_n = 1;
    // fixed priority: requester 0 monopolises until it drops at cycle 20
    x_we1 = 0; x_addr1 = 2'd0; x_req0 = 1; x_req1 = 1;
    c0 = 0; c1 = 0; lf1 = 0; rdf = 8'h00;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k <= 20) begin c0 += int'(fx_ack0); c1 += int'(fx_ack1); end
      if (fx_ack1 && lf1 == 0) begin lf1 = k; rdf = fx_rdata; end
      if (k == 20) x_req0 = 0;
    end
    x_req1 = 0;
    chk("fx_ack0_count", c0, 3);
    chk("fx_ack1_count", c1, 0);
    chk("fx_ack1_cycle", lf1, 29);
    chk("fx_rdata", rdf, 8'hA5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
